// File: rtl/spi_slave.sv
// SPI mode-0 slave. sclk, cs and mosi are resynchronised into the clk
// domain. Words are received MSB first on sclk rising edges and transmitted
// MSB first, shifting on sclk falling edges. Back-to-back words are
// supported while cs stays low.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [DATA_W-1:0]      rx_shift, rx_shift_nxt, rx_shift_in;
  logic [DATA_W-1:0]      tx_shift, tx_shift_nxt;
  logic [DATA_W-1:0]      rx_data_nxt;
  logic                   hold, hold_nxt;
  logic                   miso_nxt, tx_ack_nxt, rx_valid_nxt, frame_err_nxt;

  // Synchroniser chains plus one extra registered copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign cs_fall     = ~cs_s & cs_d;
  assign busy        = ~cs_s;
  assign rx_shift_in = {rx_shift[DATA_W-2:0], mosi_s};

  // Next-state and datapath decode. After a word-boundary reload the new
  // MSB is already on miso, so the falling edge that follows the last bit
  // must not shift it away (hold).
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rx_shift_nxt  = rx_shift;
    tx_shift_nxt  = tx_shift;
    rx_data_nxt   = rx_data;
    hold_nxt      = hold;
    tx_ack_nxt    = 1'b0;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt    = SHIFT;
          cnt_nxt      = '0;
          tx_shift_nxt = tx_data;
          tx_ack_nxt   = 1'b1;
          hold_nxt     = 1'b0;
          // A coincident sclk rise is bit 0 of the new word.
          if (sclk_rise) begin
            rx_shift_nxt = rx_shift_in;
            cnt_nxt      = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          hold_nxt      = 1'b0;
          frame_err_nxt = (cnt != '0);
        end else if (sclk_rise) begin
          rx_shift_nxt = rx_shift_in;
          if (cnt == LAST_BIT) begin
            rx_data_nxt  = rx_shift_in;
            rx_valid_nxt = 1'b1;
            cnt_nxt      = '0;
            tx_shift_nxt = tx_data;
            tx_ack_nxt   = 1'b1;
            hold_nxt     = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (sclk_fall) begin
          if (hold) begin
            hold_nxt = 1'b0;
          end else begin
            tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    miso_nxt = (state_nxt == SHIFT) ? tx_shift_nxt[DATA_W-1] : 1'b0;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= 1'b0;
      rx_data   <= '0;
      miso      <= 1'b0;
      tx_ack    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      rx_data   <= rx_data_nxt;
      miso      <= miso_nxt;
      tx_ack    <= tx_ack_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Shift registers carry only data and need no reset.
  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_nxt;
    tx_shift <= tx_shift_nxt;
  end

endmodule
